// File: rtl/ahci_fis_data_framer_if.sv
// Command, read-DMA payload and link-layer signals of the SATA Data FIS framer.
interface ahci_fis_data_framer_if #(
    parameter int DW_CNT_BITS = 20
);
    logic                   start;
    logic [DW_CNT_BITS-1:0] dw_cnt;
    logic [3:0]             pm_port;
    logic                   abort;
    logic                   busy;
    logic                   done;
    logic                   err;
    logic [31:0]            din;
    logic                   din_vld;
    logic                   din_re;
    logic [31:0]            dout;
    logic                   dout_vld;
    logic                   dout_hdr;
    logic                   dout_last;
    logic                   dout_re;
    logic                   fis_ack;
    logic                   fis_nak;

    // Framer side.
    modport master (
        input  start, dw_cnt, pm_port, abort,
        input  din, din_vld,
        input  dout_re, fis_ack, fis_nak,
        output busy, done, err, din_re,
        output dout, dout_vld, dout_hdr, dout_last
    );

    // Command layer, read-DMA FIFO and link layer side.
    modport slave (
        output start, dw_cnt, pm_port, abort,
        output din, din_vld,
        output dout_re, fis_ack, fis_nak,
        input  busy, done, err, din_re,
        input  dout, dout_vld, dout_hdr, dout_last
    );
endinterface

// File: rtl/ahci_fis_data_framer.sv
// Splits a command's DWORD stream into header-prefixed SATA Data FISes, waiting for R_OK/R_ERR per FIS.
// Header 2 cycles after start, payload 1 cycle din->dout; single output register stalls din while dout_re=0.
module ahci_fis_data_framer #(
    parameter int MAX_FIS_DW  = 2048,
    parameter int DW_CNT_BITS = 20
) (
    input  logic                   mclk,
    input  logic                   mrst_n,
    ahci_fis_data_framer_if.master bus
);
    localparam int FCNT_BITS = $clog2(MAX_FIS_DW) + 1;
    localparam int REM_BITS  = DW_CNT_BITS + 1;

    localparam logic [REM_BITS-1:0]  MAX_REM       = REM_BITS'(MAX_FIS_DW);
    localparam logic [FCNT_BITS-1:0] MAX_FCNT      = FCNT_BITS'(MAX_FIS_DW);
    localparam logic [FCNT_BITS-1:0] FCNT_ONE      = FCNT_BITS'(1);
    localparam logic [REM_BITS-1:0]  REM_ONE       = REM_BITS'(1);
    localparam logic [7:0]           FIS_TYPE_DATA = 8'h46;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HDR      = 2'd1,
        DATA     = 2'd2,
        WAIT_ACK = 2'd3
    } state_t;

    typedef struct packed {
        logic [15:0] rsvd_hi;
        logic [3:0]  rsvd_lo;
        logic [3:0]  pm_port;
        logic [7:0]  fis_type;
    } hdr_t;

    state_t                 state_q, state_d;
    logic [REM_BITS-1:0]    rem_q, rem_d;
    logic [FCNT_BITS-1:0]   fcnt_q, fcnt_d;
    logic [3:0]             pm_q, pm_d;
    logic [31:0]            dout_q, dout_d;
    logic                   dout_vld_q, dout_vld_d;
    logic                   dout_hdr_q, dout_hdr_d;
    logic                   dout_last_q, dout_last_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic                   din_re;
    logic                   out_free;
    hdr_t                   hdr_w;

    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            rem_q       <= '0;
            fcnt_q      <= '0;
            pm_q        <= '0;
            dout_q      <= '0;
            dout_vld_q  <= 1'b0;
            dout_hdr_q  <= 1'b0;
            dout_last_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            rem_q       <= rem_d;
            fcnt_q      <= fcnt_d;
            pm_q        <= pm_d;
            dout_q      <= dout_d;
            dout_vld_q  <= dout_vld_d;
            dout_hdr_q  <= dout_hdr_d;
            dout_last_q <= dout_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        fcnt_d      = fcnt_q;
        pm_d        = pm_q;
        dout_d      = dout_q;
        dout_vld_d  = dout_vld_q;
        dout_hdr_d  = dout_hdr_q;
        dout_last_d = dout_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        din_re      = 1'b0;

        hdr_w          = '0;
        hdr_w.pm_port  = pm_q;
        hdr_w.fis_type = FIS_TYPE_DATA;

        // The output register can take a new DWORD if empty or draining this cycle.
        out_free = !dout_vld_q || bus.dout_re;

        if (dout_vld_q && bus.dout_re) begin
            dout_vld_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    rem_d   = REM_BITS'(bus.dw_cnt) + REM_ONE;
                    pm_d    = bus.pm_port;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (out_free) begin
                    dout_d      = hdr_w;
                    dout_vld_d  = 1'b1;
                    dout_hdr_d  = 1'b1;
                    dout_last_d = 1'b0;
                    fcnt_d      = (rem_q >= MAX_REM) ? MAX_FCNT : rem_q[FCNT_BITS-1:0];
                    state_d     = DATA;
                end
            end
            DATA: begin
                din_re = bus.din_vld && out_free;
                if (din_re) begin
                    dout_d      = bus.din;
                    dout_vld_d  = 1'b1;
                    dout_hdr_d  = 1'b0;
                    dout_last_d = (fcnt_q == FCNT_ONE);
                    fcnt_d      = fcnt_q - FCNT_ONE;
                    rem_d       = rem_q - REM_ONE;
                    if (fcnt_q == FCNT_ONE) begin
                        state_d = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                // The link only reports a result once it has taken the final DWORD.
                if (!dout_vld_q) begin
                    if (bus.fis_nak) begin
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else if (bus.fis_ack) begin
                        if (rem_q == '0) begin
                            done_d  = 1'b1;
                            err_d   = 1'b0;
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            state_d = HDR;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            dout_vld_d = 1'b0;
            done_d     = 1'b1;
            err_d      = 1'b1;
            busy_d     = 1'b0;
        end
    end

    assign bus.din_re    = din_re;
    assign bus.dout      = dout_q;
    assign bus.dout_vld  = dout_vld_q;
    assign bus.dout_hdr  = dout_hdr_q;
    assign bus.dout_last = dout_last_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: doc/ahci_fis_data_framer.md
# ahci_fis_data_framer

Downstream consumer of the read-DMA FIFO in the mclk domain: takes the word-aligned 32-bit DWORD stream produced for one command and splits it into SATA Data FISes of at most MAX_FIS_DW payload DWORDs each. Each FIS is prefixed with a Data FIS header DWORD (type 0x46, PM port). After each FIS the block waits for the link layer's R_OK/R_ERR result before sending the next one. It reports completion or error to the command layer.

## Interface
- MAX_FIS_DW, 2048: maximum payload DWORDs per Data FIS; power of 2, range 16..2048.
- DW_CNT_BITS, 20: width of the total DWORD counter.

- mclk  in  1  clock
- mrst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; latches dw_cnt and pm_port; ignored while busy=1
- dw_cnt  in  DW_CNT_BITS  total payload DWORDs minus 1 (0-based: 0 means 1 DWORD); valid at start
- pm_port  in  4  port multiplier port for header bits [11:8]; valid at start
- abort  in  1  terminate current transfer from any state
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at end of transfer (success, NAK or abort)
- err  out  1  valid with done: 1 = terminated by fis_nak or abort
- din  in  32  payload DWORD from the read-DMA FIFO
- din_vld  in  1  din valid
- din_re  out  1  din consumed this cycle
- dout  out  32  DWORD to the link layer (registered)
- dout_vld  out  1  dout holds a DWORD
- dout_hdr  out  1  dout is a FIS header DWORD
- dout_last  out  1  dout is the last payload DWORD of the current FIS
- dout_re  in  1  link accepts dout this cycle (effective only when dout_vld=1)
- fis_ack  in  1  link: last FIS received OK (R_OK)
- fis_nak  in  1  link: last FIS failed (R_ERR / sync escape)

## Operation
- State machine states: IDLE, HDR, DATA, WAIT_ACK.
- Registers:
  - rem: payload DWORDs remaining in the command, DW_CNT_BITS+1 bits, loaded with dw_cnt+1.
  - fcnt: DWORDs remaining in the current FIS, log2(MAX_FIS_DW)+1 bits.
  - pm_r: latched pm_port.
- IDLE, start=1: load rem and pm_r, go to HDR, busy<=1.
- HDR: when the output register is free (dout_vld=0, or dout_re=1):
  - load dout = {16'h0000, 4'h0, pm_r, 8'h46}, dout_hdr=1, dout_last=0.
  - fcnt <= min(rem, MAX_FIS_DW).
  - go to DATA.
- DATA:
  - din_re = din_vld && (!dout_vld || dout_re); combinational, asserted in DATA only.
  - Each din_re loads dout <= din, dout_hdr=0, and decrements fcnt and rem.
  - dout_last=1 is set when the loaded DWORD has fcnt==1; then go to WAIT_ACK.
- WAIT_ACK:
  - Wait for the final dout to drain (dout_vld=0), then for fis_ack or fis_nak.
  - fis_ack with rem==0: done=1, err=0, busy<=0, go to IDLE.
  - fis_ack with rem!=0: go to HDR.
  - fis_nak: done=1, err=1, busy<=0, go to IDLE. Unconsumed upstream data is not flushed; the command layer resets the DMA path.
- fis_ack/fis_nak outside WAIT_ACK: ignored. Both asserted together: fis_nak wins.
- abort while busy:
  - next cycle: IDLE, dout_vld=0, done=1, err=1.
  - abort in IDLE has no effect and produces no done pulse.
- Arithmetic:
  - Header fields above bit 11 are always 0.
  - rem never underflows; the DATA exit condition is fcnt==1 on load.
  - dw_cnt = 2^DW_CNT_BITS-1 is legal (rem is one bit wider).

## Timing
- Reset (mrst_n=0, asynchronous): state=IDLE; busy=0, done=0, err=0, dout=0, dout_vld=0, dout_hdr=0, dout_last=0; din_re=0; rem=0, fcnt=0.
- start in cycle N: busy=1 in N+1; header on dout with dout_vld=1 in N+2.
- Payload latency: din accepted in cycle K appears on dout with dout_vld=1 in K+1.
- Full throughput of 1 DWORD/cycle when din_vld=1 and dout_re=1 continuously.
- dout, dout_hdr and dout_last hold stable while dout_vld=1 && dout_re=0; no bubbles are inserted between header and payload.
- fis_ack in cycle M (rem!=0): next header on dout in M+2. fis_ack/nak in cycle M (final): done pulse in M+1.
- done and err are registered; err holds its value until the next start.

## Test plan
- Single short FIS: dw_cnt=3, pm_port=5, din 0x11..0x14 always valid, dout_re=1 -> dout sequence 0x00000546(hdr), 0x11, 0x12, 0x13, 0x14(last); fis_ack -> done=1, err=0, busy=0.
- Split: MAX_FIS_DW=16, dw_cnt=39 -> three FISes of 16, 16 and 8 payload DWORDs, each preceded by a header, with dout_last on the 16th, 32nd and 40th payload DWORD; after three acks, done=1, err=0.
- Backpressure: dw_cnt=7, dout_re toggling 1/0 and din_vld random -> dout stable while stalled, no DWORD lost or duplicated, payload order preserved, din_re never asserted while dout_vld=1 && dout_re=0.
- NAK: MAX_FIS_DW=16, dw_cnt=31, fis_nak after the first FIS -> done=1, err=1, no second header emitted; fis_ack and fis_nak together -> treated as NAK.
- Abort mid-DATA after 5 payload DWORDs -> IDLE next cycle, dout_vld=0, done=1, err=1; a new start then runs cleanly. start while busy -> ignored.
- Async reset asserted mid-FIS without a clock edge -> all outputs 0 immediately. Boundary: dw_cnt=0 -> header plus 1 DWORD with dout_last=1.
